// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one heap-memory read port among NumReq clients.
// One read in flight at a time; a read that gets no data in time completes with an error.
module mem_read_arbiter #(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumReq-1:0]           cl_req,
    input  logic [NumReq*AddrWidth-1:0] cl_addr,
    output logic [NumReq-1:0]           cl_rsp_valid,
    output logic [DataWidth-1:0]        cl_rsp_data,
    output logic                        cl_rsp_err,
    output logic                        mem_req,
    output logic [AddrWidth-1:0]        mem_addr,
    input  logic                        mem_data_ready,
    input  logic [DataWidth-1:0]        mem_data,
    output logic                        busy
);

    localparam int GW = $clog2(NumReq);
    localparam int CW = $clog2(TimeoutCycles + 1);
    localparam logic [CW-1:0] CntLast = CW'(TimeoutCycles - 1);
    localparam logic [GW-1:0] GrantInit = GW'(NumReq - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [GW-1:0]         grant, grant_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [NumReq-1:0]     valid_n;
    logic [DataWidth-1:0]  data_n;
    logic                  err_n;
    logic                  mem_req_n;
    logic [AddrWidth-1:0]  mem_addr_n;
    logic                  found;
    logic [GW-1:0]         win;

    // Search starts just past the last grant so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = grant;
        for (int i = 1; i <= NumReq; i++) begin
            if (!found && cl_req[(int'(grant) + i) % NumReq]) begin
                found = 1'b1;
                win   = GW'((int'(grant) + i) % NumReq);
            end
        end
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        cnt_n      = cnt;
        valid_n    = '0;
        data_n     = cl_rsp_data;
        err_n      = cl_rsp_err;
        mem_req_n  = 1'b0;
        mem_addr_n = mem_addr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_n    = win;
                    mem_addr_n = cl_addr[int'(win)*AddrWidth +: AddrWidth];
                    mem_req_n  = 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (mem_data_ready) begin
                    data_n  = mem_data;
                    err_n   = 1'b0;
                    valid_n = NumReq'(1) << grant;
                    state_n = RESP;
                end else if (cnt >= CntLast) begin
                    data_n  = '0;
                    err_n   = 1'b1;
                    valid_n = NumReq'(1) << grant;
                    state_n = RESP;
                end else begin
                    cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            grant        <= GrantInit;
            cnt          <= '0;
            cl_rsp_valid <= '0;
            cl_rsp_data  <= '0;
            cl_rsp_err   <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            cnt          <= cnt_n;
            cl_rsp_valid <= valid_n;
            cl_rsp_data  <= data_n;
            cl_rsp_err   <= err_n;
            mem_req      <= mem_req_n;
            mem_addr     <= mem_addr_n;
            busy         <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a 1-cycle-latency memory model.
// Each scenario task drives stimulus and checks hand-computed expectations.
module tb_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cl_req = 2'b00;
    logic [31:0] cl_addr = '0;
    logic [1:0]  cl_rsp_valid;
    logic [15:0] cl_rsp_data;
    logic        cl_rsp_err;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_data_ready;
    logic [15:0] mem_data = '0;
    logic        busy;

    logic        mem_on = 1'b1;
    logic        late = 1'b0;
    logic        rdy_q = 1'b0;
    logic [15:0] mem [0:15];
    int          req_cnt = 0;
    int          rsp_cnt = 0;
    int          total = 0;
    int          passed = 0;

    mem_read_arbiter #(
        .NumReq(2), .AddrWidth(16), .DataWidth(16), .TimeoutCycles(8)
    ) dut (
        .clk(clk), .rst(rst), .cl_req(cl_req), .cl_addr(cl_addr),
        .cl_rsp_valid(cl_rsp_valid), .cl_rsp_data(cl_rsp_data),
        .cl_rsp_err(cl_rsp_err), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_ready(mem_data_ready), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_data_ready = rdy_q | late;

    always @(posedge clk) begin
        rdy_q <= mem_on && mem_req;
        if (mem_req) mem_data <= mem[mem_addr[3:0]];
        if (mem_req) req_cnt <= req_cnt + 1;
        if (cl_rsp_valid != 2'b00) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        cl_req = 2'b00;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (cl_rsp_valid == 2'b00 && n < 30);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        total++;
        if ({mem_req, busy, cl_rsp_valid, cl_rsp_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mem_req, busy, cl_rsp_valid, cl_rsp_err});
        else passed++;
        total++;
        if ({mem_addr, cl_rsp_data} !== 32'h0)
            $display("FAIL reset_data: got %h want 0", {mem_addr, cl_rsp_data});
        else passed++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        cl_addr = {16'h0000, 16'h0002};
        cl_req = 2'b01;
        step();
        total++;
        if ({mem_req, busy, mem_addr} !== {1'b1, 1'b1, 16'h0002})
            $display("FAIL single_c1: got %b %b %h want 1 1 0002", mem_req, busy, mem_addr);
        else passed++;
        step();
        total++;
        if ({mem_req, busy, cl_rsp_valid} !== 4'b0100)
            $display("FAIL single_c2: got %b want 0100", {mem_req, busy, cl_rsp_valid});
        else passed++;
        step();
        total++;
        if ({cl_rsp_valid, cl_rsp_data, cl_rsp_err, busy} !== {2'b01, 16'h789A, 1'b0, 1'b1})
            $display("FAIL single_c3: got %b %h %b %b want 01 789a 0 1",
                     cl_rsp_valid, cl_rsp_data, cl_rsp_err, busy);
        else passed++;
        cl_req = 2'b00;
        step();
        total++;
        if ({cl_rsp_valid, busy, cl_rsp_data} !== {2'b00, 1'b0, 16'h789A})
            $display("FAIL single_c4: got %b %b %h want 00 0 789a",
                     cl_rsp_valid, busy, cl_rsp_data);
        else passed++;
    endtask

    task automatic test_contention();
        int n;
        reset_dut();
        cl_addr = {16'h0003, 16'h0000};
        cl_req = 2'b11;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b01, 16'h0000} || n != 3)
            $display("FAIL cont_first: got %b %h n=%0d want 01 0000 n=3",
                     cl_rsp_valid, cl_rsp_data, n);
        else passed++;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b10, 16'h0001} || n != 4)
            $display("FAIL cont_second: got %b %h n=%0d want 10 0001 n=4",
                     cl_rsp_valid, cl_rsp_data, n);
        else passed++;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b01, 16'h0000})
            $display("FAIL cont_third: got %b %h want 01 0000", cl_rsp_valid, cl_rsp_data);
        else passed++;
        cl_req = 2'b00;
        step();
    endtask

    task automatic test_fairness();
        int n;
        reset_dut();
        cl_addr = {16'h0003, 16'h0002};
        cl_req = 2'b10;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b10, 16'h0001})
            $display("FAIL fair_c1: got %b %h want 10 0001", cl_rsp_valid, cl_rsp_data);
        else passed++;
        cl_req = 2'b11;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b01, 16'h789A} || n != 4)
            $display("FAIL fair_c0: got %b %h n=%0d want 01 789a n=4",
                     cl_rsp_valid, cl_rsp_data, n);
        else passed++;
        cl_req = 2'b10;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b10, 16'h0001})
            $display("FAIL fair_c1b: got %b %h want 10 0001", cl_rsp_valid, cl_rsp_data);
        else passed++;
        cl_req = 2'b00;
        step();
    endtask

    task automatic test_timeout();
        int n;
        logic [1:0] seen;
        mem_on = 1'b0;
        cl_addr = {16'h0000, 16'h0002};
        cl_req = 2'b01;
        step();
        total++;
        if (mem_req !== 1'b1)
            $display("FAIL tmo_issue: got mem_req=%b want 1", mem_req);
        else passed++;
        late = 1'b1;
        step();
        late = 1'b0;
        wait_rsp(n);
        total++;
        if (n != 8)
            $display("FAIL tmo_latency: got %0d wait cycles want 8", n);
        else passed++;
        total++;
        if ({cl_rsp_valid, cl_rsp_err, cl_rsp_data} !== {2'b01, 1'b1, 16'h0000})
            $display("FAIL tmo_rsp: got %b %b %h want 01 1 0000",
                     cl_rsp_valid, cl_rsp_err, cl_rsp_data);
        else passed++;
        cl_req = 2'b00;
        late = 1'b1;
        seen = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            seen |= cl_rsp_valid;
        end
        late = 1'b0;
        total++;
        if ({seen, busy} !== 3'b000)
            $display("FAIL tmo_late: got %b %b want 00 0", seen, busy);
        else passed++;
        mem_on = 1'b1;
        step();
    endtask

    task automatic test_reset_wait();
        int n;
        logic [1:0] seen;
        cl_addr = {16'h0003, 16'h0002};
        cl_req = 2'b01;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({mem_req, busy} !== 2'b00)
            $display("FAIL rst_issue: got %b want 00", {mem_req, busy});
        else passed++;
        cl_req = 2'b00;
        step();
        rst = 1'b1;
        step();
        cl_req = 2'b01;
        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({mem_req, busy, cl_rsp_valid} !== 4'b0000)
            $display("FAIL rst_wait: got %b want 0000", {mem_req, busy, cl_rsp_valid});
        else passed++;
        cl_req = 2'b00;
        seen = 2'b00;
        step();
        seen |= cl_rsp_valid;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            seen |= cl_rsp_valid;
        end
        total++;
        if (seen !== 2'b00)
            $display("FAIL rst_norsp: got %b want 00", seen);
        else passed++;
        cl_req = 2'b11;
        wait_rsp(n);
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b01, 16'h789A} || n != 3)
            $display("FAIL rst_regrant: got %b %h n=%0d want 01 789a n=3",
                     cl_rsp_valid, cl_rsp_data, n);
        else passed++;
        cl_req = 2'b00;
        step();
    endtask

    task automatic test_drop();
        int req0;
        int rsp0;
        req0 = req_cnt;
        rsp0 = rsp_cnt;
        cl_addr = {16'h0003, 16'h0002};
        cl_req = 2'b01;
        step();
        step();
        cl_req = 2'b00;
        step();
        total++;
        if ({cl_rsp_valid, cl_rsp_data} !== {2'b01, 16'h789A})
            $display("FAIL drop_rsp: got %b %h want 01 789a", cl_rsp_valid, cl_rsp_data);
        else passed++;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (rsp_cnt - rsp0 != 1)
            $display("FAIL drop_rspcnt: got %0d want 1", rsp_cnt - rsp0);
        else passed++;
        total++;
        if (req_cnt - req0 != rsp_cnt - rsp0)
            $display("FAIL drop_balance: got req=%0d rsp=%0d want equal",
                     req_cnt - req0, rsp_cnt - rsp0);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[2] = 16'h789A;
        mem[3] = 16'h0001;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_wait();
        test_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
